lsu_mem_port: RTL and testbench

Load/store initiator that drives one port of the team's byte-enable dual-port data RAM on behalf of the core's memory stage. It accepts byte-addressed load and store requests of byte, half or word size through a valid/ready handshake. Each request becomes one or two word accesses with byte write-enables. Loads are returned sign- or zero-extended. Accesses that straddle a word boundary are split into two RAM accesses and merged transparently.

---
 rtl/lsu_pkg.sv | 11 +
 rtl/lsu_align.sv | 75 +++++++
 rtl/lsu_mem_port.sv | 185 ++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory port: access sizes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DATA} state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for one load/store: builds the two-word byte masks and
// store data from the byte offset, and assembles/extends the load result.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic [1:0]            i_off,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_word0,
  input  logic [DATA_WIDTH-1:0] i_word1,
  output logic                  o_split,
  output logic [NUM_COL-1:0]    o_mask_lo,
  output logic [NUM_COL-1:0]    o_mask_hi,
  output logic [DATA_WIDTH-1:0] o_wd_lo,
  output logic [DATA_WIDTH-1:0] o_wd_hi,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [2*NUM_COL-1:0]    w_base;
  logic [2*NUM_COL-1:0]    w_mask8;
  logic [2*DATA_WIDTH-1:0] w_wz;
  logic [2*DATA_WIDTH-1:0] w_wd64;
  logic [DATA_WIDTH-1:0]   w_lo;

  // Unshifted lane mask and zero-extended store data for the access size
  always_comb begin
    w_base = '0;
    w_wz   = '0;
    case (i_size)
      SZ_B: begin
        w_base[0]              = 1'b1;
        w_wz[COL_WIDTH-1:0]    = i_wdata[COL_WIDTH-1:0];
      end
      SZ_H: begin
        w_base[1:0]            = 2'b11;
        w_wz[2*COL_WIDTH-1:0]  = i_wdata[2*COL_WIDTH-1:0];
      end
      SZ_W: begin
        w_base[NUM_COL-1:0]    = '1;
        w_wz[DATA_WIDTH-1:0]   = i_wdata;
      end
      default: ;
    endcase
  end

  // Shift into place across a two-word window; anything in the upper word means a split access
  assign w_mask8   = w_base << i_off;
  assign w_wd64    = w_wz << (int'(i_off) * COL_WIDTH);
  assign o_mask_lo = w_mask8[NUM_COL-1:0];
  assign o_mask_hi = w_mask8[2*NUM_COL-1:NUM_COL];
  assign o_split   = |w_mask8[2*NUM_COL-1:NUM_COL];
  assign o_wd_lo   = w_wd64[DATA_WIDTH-1:0];
  assign o_wd_hi   = w_wd64[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_lo      = DATA_WIDTH'({i_word1, i_word0} >> (int'(i_off) * COL_WIDTH));

  // Keep the low n bytes of the realigned load and sign/zero extend
  always_comb begin
    o_rdata = w_lo;
    case (i_size)
      SZ_B: o_rdata = i_unsigned
          ? {{(DATA_WIDTH-COL_WIDTH){1'b0}}, w_lo[COL_WIDTH-1:0]}
          : {{(DATA_WIDTH-COL_WIDTH){w_lo[COL_WIDTH-1]}}, w_lo[COL_WIDTH-1:0]};
      SZ_H: o_rdata = i_unsigned
          ? {{(DATA_WIDTH-2*COL_WIDTH){1'b0}}, w_lo[2*COL_WIDTH-1:0]}
          : {{(DATA_WIDTH-2*COL_WIDTH){w_lo[2*COL_WIDTH-1]}}, w_lo[2*COL_WIDTH-1:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator for one byte-enable RAM port. Each request becomes one
// or two word accesses; split loads are merged from a buffered first word.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_ena,
  output logic [NUM_COL-1:0]    mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  state_t                r_state;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [1:0]            r_off;
  logic [ADDR_WIDTH-1:0] r_wa;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_split;
  logic [DATA_WIDTH-1:0] r_word0;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_mem_ena;
  logic [NUM_COL-1:0]    r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_din;

  logic                  w_idle;
  logic [1:0]            w_off;
  logic [1:0]            w_size;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_word0;
  logic                  w_split;
  logic [NUM_COL-1:0]    w_mask_lo;
  logic [NUM_COL-1:0]    w_mask_hi;
  logic [DATA_WIDTH-1:0] w_wd_lo;
  logic [DATA_WIDTH-1:0] w_wd_hi;
  logic [DATA_WIDTH-1:0] w_rdata;

  // In IDLE the aligner looks at the live request so the first access can be registered at accept
  assign w_idle  = (r_state == IDLE);
  assign w_off   = w_idle ? req_addr[1:0] : r_off;
  assign w_size  = w_idle ? req_size      : r_size;
  assign w_wdata = w_idle ? req_wdata     : r_wdata;
  assign w_word0 = r_split ? r_word0 : mem_dout;

  lsu_align #(
    .NUM_COL   (NUM_COL),
    .COL_WIDTH (COL_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .i_off     (w_off),
    .i_size    (w_size),
    .i_unsigned(r_unsigned),
    .i_wdata   (w_wdata),
    .i_word0   (w_word0),
    .i_word1   (mem_dout),
    .o_split   (w_split),
    .o_mask_lo (w_mask_lo),
    .o_mask_hi (w_mask_hi),
    .o_wd_lo   (w_wd_lo),
    .o_wd_hi   (w_wd_hi),
    .o_rdata   (w_rdata)
  );

  assign req_ready = w_idle;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_ena   = r_mem_ena;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;

  // Access sequencer: registers each RAM access one state ahead, buffers word0, issues the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_size      <= SZ_B;
      r_unsigned  <= 1'b0;
      r_off       <= '0;
      r_wa        <= '0;
      r_wdata     <= '0;
      r_split     <= 1'b0;
      r_word0     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_ena   <= 1'b0;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_off      <= req_addr[1:0];
            r_wa       <= req_addr[ADDR_WIDTH+1:2];
            r_wdata    <= req_wdata;
            r_split    <= w_split;
            if (req_size == SZ_X) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_state    <= ACC0;
              r_mem_ena  <= 1'b1;
              r_mem_addr <= req_addr[ADDR_WIDTH+1:2];
              r_mem_we   <= req_we ? w_mask_lo : '0;
              r_mem_din  <= w_wd_lo;
            end
          end
        end
        ACC0: begin
          if (r_split) begin
            r_state    <= ACC1;
            r_mem_addr <= r_wa + ADDR_WIDTH'(1);
            r_mem_we   <= r_we ? w_mask_hi : '0;
            r_mem_din  <= w_wd_hi;
          end else begin
            r_mem_ena  <= 1'b0;
            r_mem_we   <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            if (r_we) begin
              r_state     <= IDLE;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_rsp_rdata <= '0;
            end else begin
              r_state <= DATA;
            end
          end
        end
        ACC1: begin
          r_word0    <= mem_dout;
          r_mem_ena  <= 1'b0;
          r_mem_we   <= '0;
          r_mem_addr <= '0;
          r_mem_din  <= '0;
          if (r_we) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
          end else begin
            r_state <= DATA;
          end
        end
        DATA: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= w_rdata;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port with a byte-enable RAM model: directed requests push
// expected responses into a scoreboard that a negedge monitor pops and checks.
module tb_lsu_mem_port;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_ena;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;

  logic        pre_en;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] ram [0:1023];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {string nm; logic [31:0] d; logic e; int at;} exp_t;
  typedef struct {logic [9:0] a; logic [3:0] we; logic [31:0] din;} acc_t;
  exp_t sb_q[$];
  acc_t acc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_mem_port #(.ADDR_WIDTH(10), .NUM_COL(4), .COL_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_ena(mem_ena), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // RAM model: byte-enable write, read-first registered read, output held while disabled
  always @(posedge clk) begin
    if (pre_en) begin
      ram[pre_addr] <= pre_data;
    end else if (mem_ena) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      mem_dout <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Access logger
  always @(negedge clk) begin
    if (mem_ena === 1'b1) acc_q.push_back('{mem_addr, mem_we, mem_din});
  end

  // Response monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%b, want no response", rsp_rdata, rsp_err);
      end else begin
        e = sb_q.pop_front();
        chk({e.nm, "_rdata"}, rsp_rdata, e.d);
        chk({e.nm, "_err"}, {31'b0, rsp_err}, {31'b0, e.e});
        chk({e.nm, "_cycle"}, cyc, e.at);
        $display("txn %-14s rdata=%h err=%b cyc=%0d", e.nm, rsp_rdata, rsp_err, cyc);
      end
    end
  end

  task automatic issue(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e, input int lat,
                       output int c0);
    int   g = 0;
    exp_t e;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    while (req_ready !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    c0 = cyc;
    if (req_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_accept: got req_ready=%b want 1", nm, req_ready);
    end else begin
      e.nm = nm; e.d = exp_d; e.e = exp_e; e.at = cyc + lat;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    // Scramble the inputs after accept; the block must use its captured copy
    req_valid = 1'b0; req_we = ~we; req_size = sz ^ 2'd1; req_unsigned = ~uns;
    req_addr = ~addr; req_wdata = ~wd;
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() != 0 && g < 40) begin
      @(posedge clk);
      g++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d outstanding want 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  task automatic chk_acc(input string nm, input int idx, input logic [9:0] a,
                         input logic [3:0] we, input logic [31:0] din);
    if (idx >= acc_q.size()) begin
      total++;
      bad++;
      $display("FAIL %s_present: got %0d accesses want more than %0d", nm, acc_q.size(), idx);
    end else begin
      chk({nm, "_addr"}, 32'(acc_q[idx].a), 32'(a));
      chk({nm, "_we"}, 32'(acc_q[idx].we), 32'(we));
      chk({nm, "_din"}, acc_q[idx].din, din);
    end
  endtask

  initial begin
    int c0, c1, g;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_ena", 32'(mem_ena), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Aligned word round trip, load presented back-to-back with the store response
    acc_q.delete();
    issue("sw_0x010", 1'b1, SZ_W, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2, c0);
    issue("lw_0x010", 1'b0, SZ_W, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3, c1);
    drain();
    chk("sw_lw_b2b_accept", c1, c0 + 2);
    chk("sw_lw_n_acc", acc_q.size(), 32'd2);
    chk_acc("sw_0x010_acc", 0, 10'd4, 4'b1111, 32'hDEADBEEF);
    chk_acc("lw_0x010_acc", 1, 10'd4, 4'b0000, 32'h0);

    // Sub-word loads and a byte store
    preset(10'd4, 32'h80FF7F01);
    issue("lb_0x013", 1'b0, SZ_B, 1'b0, 12'h013, 32'h0, 32'hFFFFFF80, 1'b0, 3, c0);
    issue("lbu_0x013", 1'b0, SZ_B, 1'b1, 12'h013, 32'h0, 32'h00000080, 1'b0, 3, c0);
    issue("lh_0x012", 1'b0, SZ_H, 1'b0, 12'h012, 32'h0, 32'hFFFF80FF, 1'b0, 3, c0);
    issue("lhu_0x012", 1'b0, SZ_H, 1'b1, 12'h012, 32'h0, 32'h000080FF, 1'b0, 3, c0);
    issue("lb_0x010", 1'b0, SZ_B, 1'b0, 12'h010, 32'h0, 32'h00000001, 1'b0, 3, c0);
    issue("lh_0x011", 1'b0, SZ_H, 1'b0, 12'h011, 32'h0, 32'hFFFFFF7F, 1'b0, 3, c0);
    drain();
    acc_q.delete();
    issue("sb_0x011", 1'b1, SZ_B, 1'b0, 12'h011, 32'h12345655, 32'h0, 1'b0, 2, c0);
    drain();
    chk_acc("sb_0x011_acc", 0, 10'd4, 4'b0010, 32'h00005500);
    issue("lw_after_sb", 1'b0, SZ_W, 1'b0, 12'h010, 32'h0, 32'h80FF5501, 1'b0, 3, c0);
    drain();

    // Split store and load
    preset(10'd1, 32'hAAAAAAAA);
    preset(10'd2, 32'hAAAAAAAA);
    acc_q.delete();
    issue("sw_0x007", 1'b1, SZ_W, 1'b0, 12'h007, 32'h11223344, 32'h0, 1'b0, 3, c0);
    drain();
    chk("sw_0x007_n_acc", acc_q.size(), 32'd2);
    chk_acc("sw_0x007_acc0", 0, 10'd1, 4'b1000, 32'h44000000);
    chk_acc("sw_0x007_acc1", 1, 10'd2, 4'b0111, 32'h00112233);
    chk("ram1_after_split", ram[1], 32'h44AAAAAA);
    chk("ram2_after_split", ram[2], 32'hAA112233);
    issue("lw_0x007", 1'b0, SZ_W, 1'b0, 12'h007, 32'h0, 32'h11223344, 1'b0, 4, c0);
    drain();

    // Address wrap on the second access
    preset(10'h3FF, 32'hAB000000);
    preset(10'h000, 32'h000000CD);
    acc_q.delete();
    issue("lhu_0xFFF", 1'b0, SZ_H, 1'b1, 12'hFFF, 32'h0, 32'h0000CDAB, 1'b0, 4, c0);
    issue("lh_0xFFF", 1'b0, SZ_H, 1'b0, 12'hFFF, 32'h0, 32'hFFFFCDAB, 1'b0, 4, c0);
    drain();
    chk_acc("wrap_acc0", 0, 10'h3FF, 4'b0000, 32'h0);
    chk_acc("wrap_acc1", 1, 10'h000, 4'b0000, 32'h0);

    // Illegal size then a load in the same cycle as the error response
    acc_q.delete();
    issue("ill_size", 1'b1, SZ_X, 1'b0, 12'h010, 32'h55555555, 32'h0, 1'b1, 1, c0);
    issue("lw_after_ill", 1'b0, SZ_W, 1'b0, 12'h010, 32'h0, 32'h80FF5501, 1'b0, 3, c1);
    drain();
    chk("ill_b2b_accept", c1, c0 + 1);
    chk("ill_n_acc", acc_q.size(), 32'd1);
    chk_acc("lw_after_ill_acc", 0, 10'd4, 4'b0000, 32'h0);

    // Reset during the second access of a split store
    preset(10'd1, 32'hAAAAAAAA);
    preset(10'd2, 32'hAAAAAAAA);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_unsigned = 1'b0;
    req_addr = 12'h007; req_wdata = 32'h11223344;
    g = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_acc0_we", 32'(mem_we), 32'b1000);
    @(negedge clk);
    chk("rst_mid_acc1_we", 32'(mem_we), 32'b0111);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_ena", 32'(mem_ena), 32'd0);
    chk("rst_mid_mem_we", 32'(mem_we), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_ram1", ram[1], 32'h44AAAAAA);
    chk("rst_mid_ram2", ram[2], 32'hAAAAAAAA);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    issue("lw_after_rst", 1'b0, SZ_W, 1'b0, 12'h007, 32'h0, 32'hAAAAAA44, 1'b0, 4, c0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
